// File: rtl/keypad_digit_entry.sv
// Debounced one-hot keypad to BCD digit entry buffer with commit register.
// Optional clear/backspace/enter keys are enabled by defining KEYPAD_FUNC_KEYS_EN.
module keypad_digit_entry #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           onehot,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            count,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic                  full,
    output logic                  overflow,
    output logic                  done,
    output logic [4*DIGITS-1:0]   value
);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    localparam logic [3:0]          DIG_N    = 4'(DIGITS);
    localparam logic [7:0]          STABLE_N = 8'(STABLE_CYCLES);
    localparam logic [4*DIGITS-1:0] EMPTY    = '1;

    state_t                state_q, state_d;
    logic [3:0]            code_q, code_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [3:0]            count_q, count_d;
    logic [3:0]            key_code_q, key_code_d;
    logic                  key_valid_q, key_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic [4*DIGITS-1:0]   bcd_push;
`ifdef KEYPAD_FUNC_KEYS_EN
    logic [4*DIGITS-1:0]   bcd_pop;
`endif

    always_comb begin
        code_d = 4'hF;
        case (onehot)
            16'h0008: code_d = 4'h0;
            16'h0080: code_d = 4'h1;
            16'h0040: code_d = 4'h2;
            16'h0020: code_d = 4'h3;
            16'h0800: code_d = 4'h4;
            16'h0400: code_d = 4'h5;
            16'h0200: code_d = 4'h6;
            16'h8000: code_d = 4'h7;
            16'h4000: code_d = 4'h8;
            16'h2000: code_d = 4'h9;
`ifdef KEYPAD_FUNC_KEYS_EN
            16'h0001: code_d = 4'hA;
            16'h0002: code_d = 4'hB;
            16'h0004: code_d = 4'hC;
`endif
            default:  code_d = 4'hF;
        endcase
    end

    // Counter restarts on the edge that registers a new code, so cnt_q==0 means "just changed".
    always_comb begin
        if (code_d != code_q)      cnt_d = 8'd0;
        else if (cnt_q == STABLE_N) cnt_d = cnt_q;
        else                        cnt_d = cnt_q + 8'd1;
    end

    always_comb begin
        bcd_push       = bcd_q;
        bcd_push[3:0]  = code_q;
        for (int i = 1; i < DIGITS; i++) bcd_push[4*i +: 4] = bcd_q[4*(i-1) +: 4];
`ifdef KEYPAD_FUNC_KEYS_EN
        bcd_pop = bcd_q;
        bcd_pop[4*(DIGITS-1) +: 4] = 4'hF;
        for (int i = 0; i < DIGITS - 1; i++) bcd_pop[4*i +: 4] = bcd_q[4*(i+1) +: 4];
`endif
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE:       if (code_q != 4'hF) state_d = PRESS_DB;
            PRESS_DB: begin
                if (cnt_q == 8'd0) state_d = IDLE;
                else if (cnt_q == STABLE_N && code_q != 4'hF) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end
            end
            HELD:       if (code_q == 4'hF) state_d = RELEASE_DB;
            RELEASE_DB: begin
                if (code_q != 4'hF)         state_d = HELD;
                else if (cnt_q == STABLE_N) state_d = IDLE;
            end
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bcd_d       = bcd_q;
        value_d     = value_q;
        count_d     = count_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        overflow_d  = 1'b0;
        done_d      = 1'b0;
        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = code_q;
            if (code_q <= 4'd9) begin
                if (count_q == DIG_N) begin
                    overflow_d = 1'b1;
                end else begin
`ifdef KEYPAD_FUNC_KEYS_EN
                    bcd_d   = bcd_push;
                    count_d = count_q + 4'd1;
`else
                    // Auto-commit: the digit filling the last slot commits the buffer.
                    if (count_q + 4'd1 == DIG_N) begin
                        value_d = bcd_push;
                        done_d  = 1'b1;
                        bcd_d   = EMPTY;
                        count_d = 4'd0;
                    end else begin
                        bcd_d   = bcd_push;
                        count_d = count_q + 4'd1;
                    end
`endif
                end
            end
`ifdef KEYPAD_FUNC_KEYS_EN
            else if (code_q == 4'hA) begin
                bcd_d   = EMPTY;
                count_d = 4'd0;
            end else if (code_q == 4'hB) begin
                if (count_q != 4'd0) begin
                    bcd_d   = bcd_pop;
                    count_d = count_q - 4'd1;
                end
            end else if (code_q == 4'hC) begin
                if (count_q != 4'd0) begin
                    value_d = bcd_q;
                    done_d  = 1'b1;
                    bcd_d   = EMPTY;
                    count_d = 4'd0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            code_q      <= 4'hF;
            cnt_q       <= 8'd0;
            bcd_q       <= EMPTY;
            value_q     <= EMPTY;
            count_q     <= 4'd0;
            key_code_q  <= 4'hF;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            value_q     <= value_d;
            count_q     <= count_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign bcd       = bcd_q;
    assign value     = value_q;
    assign count     = count_q;
    assign full      = (count_q == DIG_N);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Scoreboard bench for keypad_digit_entry: directed presses queue expected accepts,
// a negedge monitor pops and compares on every key_valid pulse.
module tb_keypad_digit_entry;

    localparam int D = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   onehot;
    logic [4*D-1:0] bcd, value;
    logic [3:0]    count, key_code;
    logic          key_valid, full, overflow, done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  code;
        logic [15:0] bcd;
        logic [3:0]  cnt;
        logic        full;
        logic        ovf;
        logic        done;
        logic [15:0] value;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    keypad_digit_entry #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .onehot(onehot), .bcd(bcd), .count(count),
        .key_valid(key_valid), .key_code(key_code), .full(full),
        .overflow(overflow), .done(done), .value(value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a pattern, then release; an accepted press is expected S+2 edges after driving.
    task automatic press(input logic [15:0] oh, input bit acc, input logic [3:0] code,
                         input logic [15:0] b, input logic [3:0] c, input logic f,
                         input logic o, input logic d, input logic [15:0] v);
        exp_t x;
        if (acc) begin
            x = '{cyc + S + 2, code, b, c, f, o, d, v};
            sb.push_back(x);
        end
        onehot = oh;
        step(10);
        onehot = 16'h0;
        step(8);
    endtask

    task automatic check_reset();
        chk("rst_bcd", bcd, 16'hFFFF);
        chk("rst_value", value, 16'hFFFF);
        chk("rst_count", count, 0);
        chk("rst_key_code", key_code, 4'hF);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
    endtask

    always @(negedge clk) begin
        chk("stray_pulse", {31'b0, (done | overflow) & ~key_valid}, 0);
        if (key_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_key_valid: got code %h, no press expected (cycle %0d)", key_code, cyc);
            end else begin
                e = sb.pop_front();
                chk("kv_cycle", cyc, e.cyc);
                chk("key_code", key_code, e.code);
                chk("bcd", bcd, e.bcd);
                chk("count", count, e.cnt);
                chk("full", full, e.full);
                chk("overflow", overflow, e.ovf);
                chk("done", done, e.done);
                chk("value", value, e.value);
            end
        end
    end

    initial begin
        exp_t x;
        rst_n  = 1'b0;
        onehot = 16'h0;
        step(3);
        check_reset();
        rst_n = 1'b1;
        step(2);

        press(16'h0080, 1, 4'h1, 16'hFFF1, 4'd1, 0, 0, 0, 16'hFFFF);

        onehot = 16'h0040;
        step(3);
        onehot = 16'h0;
        step(8);
        chk("glitch_bcd", bcd, 16'hFFF1);
        chk("glitch_count", count, 1);

`ifdef KEYPAD_FUNC_KEYS_EN
        press(16'h0040, 1, 4'h2, 16'hFF12, 4'd2, 0, 0, 0, 16'hFFFF);
        press(16'h0020, 1, 4'h3, 16'hF123, 4'd3, 0, 0, 0, 16'hFFFF);
        press(16'h0800, 1, 4'h4, 16'h1234, 4'd4, 1, 0, 0, 16'hFFFF);
        chk("full_level", full, 1);
        press(16'h0400, 1, 4'h5, 16'h1234, 4'd4, 1, 1, 0, 16'hFFFF);
        press(16'h0002, 1, 4'hB, 16'hF123, 4'd3, 0, 0, 0, 16'hFFFF);
        press(16'h0004, 1, 4'hC, 16'hFFFF, 4'd0, 0, 0, 1, 16'hF123);
        press(16'h0004, 1, 4'hC, 16'hFFFF, 4'd0, 0, 0, 0, 16'hF123);
        press(16'h0002, 1, 4'hB, 16'hFFFF, 4'd0, 0, 0, 0, 16'hF123);
        press(16'h0200, 1, 4'h6, 16'hFFF6, 4'd1, 0, 0, 0, 16'hF123);
        press(16'h0001, 1, 4'hA, 16'hFFFF, 4'd0, 0, 0, 0, 16'hF123);
        press(16'h0001, 1, 4'hA, 16'hFFFF, 4'd0, 0, 0, 0, 16'hF123);
        x = '{cyc + S + 2, 4'h0, 16'hFFF0, 4'd1, 1'b0, 1'b0, 1'b0, 16'hF123};
`else
        press(16'h0001, 0, 4'h0, 16'h0, 4'd0, 0, 0, 0, 16'h0);
        press(16'h0003, 0, 4'h0, 16'h0, 4'd0, 0, 0, 0, 16'h0);
        chk("nokey_bcd", bcd, 16'hFFF1);
        press(16'h0040, 1, 4'h2, 16'hFF12, 4'd2, 0, 0, 0, 16'hFFFF);
        press(16'h0020, 1, 4'h3, 16'hF123, 4'd3, 0, 0, 0, 16'hFFFF);
        press(16'h0800, 1, 4'h4, 16'hFFFF, 4'd0, 0, 0, 1, 16'h1234);
        press(16'h2000, 1, 4'h9, 16'hFFF9, 4'd1, 0, 0, 0, 16'h1234);
        press(16'h4000, 1, 4'h8, 16'hFF98, 4'd2, 0, 0, 0, 16'h1234);
        press(16'h8000, 1, 4'h7, 16'hF987, 4'd3, 0, 0, 0, 16'h1234);
        press(16'h0200, 1, 4'h6, 16'hFFFF, 4'd0, 0, 0, 1, 16'h9876);
        press(16'h0400, 1, 4'h5, 16'hFFF5, 4'd1, 0, 0, 0, 16'h9876);
        x = '{cyc + S + 2, 4'h0, 16'hFF50, 4'd2, 1'b0, 1'b0, 1'b0, 16'h9876};
`endif
        // Reset while the key is held: it must debounce again from scratch.
        sb.push_back(x);
        x = '{cyc + 9 + S + 2, 4'h0, 16'hFFF0, 4'd1, 1'b0, 1'b0, 1'b0, 16'hFFFF};
        sb.push_back(x);
        onehot = 16'h0008;
        step(8);
        rst_n = 1'b0;
        step(1);
        check_reset();
        rst_n = 1'b1;
        step(10);
        onehot = 16'h0;
        step(8);

        step(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
